// File: rtl/cordic_scheduler.sv
// Shares one CordicFSM between NUM_REQ requesters: per-requester operand slots,
// round-robin grant, single in-flight operation with timeout, one-hot done pulse.
module cordic_scheduler #(
    parameter int NUM_REQ       = 3,
    parameter int BIT_WIDTH_IN  = 24,
    parameter int BIT_WIDTH_OUT = 27,
    parameter int TIMEOUT       = 64
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [NUM_REQ-1:0]                req_tick_i,
    input  logic [NUM_REQ*BIT_WIDTH_IN-1:0]   req_sin_i,
    input  logic [NUM_REQ*BIT_WIDTH_IN-1:0]   req_cos_i,
    output logic [BIT_WIDTH_OUT-1:0]          res_phi_o,
    output logic [BIT_WIDTH_IN:0]             res_r_o,
    output logic [NUM_REQ-1:0]                res_done_o,
    output logic                              cordic_start_o,
    output logic [BIT_WIDTH_IN-1:0]           cordic_sin_o,
    output logic [BIT_WIDTH_IN-1:0]           cordic_cos_o,
    input  logic [BIT_WIDTH_OUT-1:0]          cordic_phi_i,
    input  logic [BIT_WIDTH_IN:0]             cordic_r_i,
    input  logic                              cordic_done_i,
    output logic                              busy_o,
    output logic [NUM_REQ-1:0]                overrun_o,
    output logic                              timeout_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                                 r_state;
    logic [NUM_REQ-1:0][BIT_WIDTH_IN-1:0]   r_sin;
    logic [NUM_REQ-1:0][BIT_WIDTH_IN-1:0]   r_cos;
    logic [NUM_REQ-1:0]                     r_pending;
    logic [NUM_REQ-1:0]                     r_overrun;
    logic [PTR_W-1:0]                       r_last;
    logic [PTR_W-1:0]                       r_grant;
    logic [CNT_W-1:0]                       r_cnt;
    logic                                   r_start;
    logic [BIT_WIDTH_IN-1:0]                r_csin;
    logic [BIT_WIDTH_IN-1:0]                r_ccos;
    logic [BIT_WIDTH_OUT-1:0]               r_phi;
    logic [BIT_WIDTH_IN:0]                  r_r;
    logic [NUM_REQ-1:0]                     r_done;
    logic                                   r_busy;
    logic                                   r_timeout;

    logic                                   w_any;
    logic [PTR_W-1:0]                       w_gnt;
    logic                                   w_issue;
    logic [NUM_REQ-1:0]                     w_clr;
    logic [NUM_REQ-1:0]                     w_grant_oh;

    // Search starts one past the last completed grant and wraps around.
    always_comb begin
        int unsigned v_idx;
        w_any = 1'b0;
        w_gnt = '0;
        v_idx = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            v_idx = 32'(r_last) + off;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            if (!w_any && r_pending[PTR_W'(v_idx)]) begin
                w_any = 1'b1;
                w_gnt = PTR_W'(v_idx);
            end
        end
    end

    assign w_issue = (r_state == S_IDLE) && w_any;

    always_comb begin
        w_clr      = '0;
        w_grant_oh = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_clr[k]      = w_issue && (w_gnt == PTR_W'(k));
            w_grant_oh[k] = (r_grant == PTR_W'(k));
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state   <= S_IDLE;
            r_sin     <= '0;
            r_cos     <= '0;
            r_pending <= '0;
            r_overrun <= '0;
            r_last    <= PTR_W'(NUM_REQ - 1);
            r_grant   <= '0;
            r_cnt     <= '0;
            r_start   <= 1'b0;
            r_csin    <= '0;
            r_ccos    <= '0;
            r_phi     <= '0;
            r_r       <= '0;
            r_done    <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_done  <= '0;

            // A tick on the slot being granted this cycle refills it rather than overrunning it.
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (req_tick_i[k]) begin
                    r_sin[k] <= req_sin_i[k*BIT_WIDTH_IN +: BIT_WIDTH_IN];
                    r_cos[k] <= req_cos_i[k*BIT_WIDTH_IN +: BIT_WIDTH_IN];
                    if (r_pending[k] && !w_clr[k]) begin
                        r_overrun[k] <= 1'b1;
                    end
                end
            end
            r_pending <= (r_pending & ~w_clr) | req_tick_i;

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_csin  <= r_sin[w_gnt];
                        r_ccos  <= r_cos[w_gnt];
                        r_grant <= w_gnt;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cordic_done_i) begin
                        r_phi   <= cordic_phi_i;
                        r_r     <= cordic_r_i;
                        r_done  <= w_grant_oh;
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_last  <= r_grant;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign res_phi_o      = r_phi;
    assign res_r_o        = r_r;
    assign res_done_o     = r_done;
    assign cordic_start_o = r_start;
    assign cordic_sin_o   = r_csin;
    assign cordic_cos_o   = r_ccos;
    assign busy_o         = r_busy;
    assign overrun_o      = r_overrun;
    assign timeout_o      = r_timeout;

endmodule
